// File: rtl/mem_arbiter_if.sv
// Word-addressed 16-bit memory bus shared by the core requesters and the memory port.
// The master drives the request; the slave returns read data and the transfer-complete ack.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BSEL_W = 2;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              access;
    logic              ack;
    logic              wr_en;
    logic [BSEL_W-1:0] bytesel;

    modport master (
        output addr, data_out, access, wr_en, bytesel,
        input  data_in, ack
    );

    modport slave (
        input  addr, data_out, access, wr_en, bytesel,
        output data_in, ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges the core's instruction and data buses onto one registered memory port.
// Fixed data priority by default; MEM_ARBITER_ROUND_ROBIN_EN alternates grants on contention.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  instr_m,
    mem_arbiter_if.slave  data_m,
    mem_arbiter_if.master q_m
);
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BSEL_W = 2;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    state_e            state_q, state_d;
    src_e              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [BSEL_W-1:0] bytesel_q, bytesel_d;
    logic              access_q, access_d;
    logic              wr_en_q, wr_en_d;
    logic              pick_data_c;

    // The prefetcher never writes, so its write-side fields are intentionally ignored.
    logic unused_instr_c;
    assign unused_instr_c = ^{instr_m.data_out, instr_m.wr_en, instr_m.bytesel};

    // Winner when the bus is idle; only consulted when at least one access is present.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        pick_data_c = data_m.access;
        if (data_m.access && instr_m.access) begin
            pick_data_c = (last_grant_q == SRC_INSTR);
        end
    end
`else
    logic unused_last_grant_c;
    assign unused_last_grant_c = last_grant_q;

    always_comb begin
        pick_data_c = data_m.access;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_INSTR;
            addr_q       <= '0;
            data_out_q   <= '0;
            bytesel_q    <= '0;
            access_q     <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            bytesel_q    <= bytesel_d;
            access_q     <= access_d;
            wr_en_q      <= wr_en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        bytesel_d    = bytesel_q;
        access_d     = access_q;
        wr_en_d      = wr_en_q;

        case (state_q)
            IDLE: begin
                if (pick_data_c) begin
                    addr_d     = data_m.addr;
                    data_out_d = data_m.data_out;
                    wr_en_d    = data_m.wr_en;
                    bytesel_d  = data_m.bytesel;
                    access_d   = 1'b1;
                    state_d    = GRANT_DATA;
                end else if (instr_m.access) begin
                    addr_d     = instr_m.addr;
                    data_out_d = '0;
                    wr_en_d    = 1'b0;
                    bytesel_d  = BSEL_W'(2'b11);
                    access_d   = 1'b1;
                    state_d    = GRANT_INSTR;
                end
            end
            GRANT_INSTR, GRANT_DATA: begin
                // Request fields stay frozen until memory completes the transfer.
                if (q_m.ack) begin
                    access_d     = 1'b0;
                    wr_en_d      = 1'b0;
                    state_d      = IDLE;
                    last_grant_d = (state_q == GRANT_DATA) ? SRC_DATA : SRC_INSTR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q_m.addr     = addr_q;
    assign q_m.data_out = data_out_q;
    assign q_m.bytesel  = bytesel_q;
    assign q_m.access   = access_q;
    assign q_m.wr_en    = wr_en_q;

    // Ack and read data reach only the requester that owns the current transfer.
    assign instr_m.ack     = (state_q == GRANT_INSTR) && q_m.ack;
    assign instr_m.data_in = (state_q == GRANT_INSTR) ? q_m.data_in : '0;
    assign data_m.ack      = (state_q == GRANT_DATA) && q_m.ack;
    assign data_m.data_in  = (state_q == GRANT_DATA) ? q_m.data_in : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level
// model and a word-addressed memory scoreboard. Honours MEM_ARBITER_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if instr_m ();
    mem_arbiter_if data_m ();
    mem_arbiter_if q_m ();

    mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .instr_m (instr_m),
        .data_m  (data_m),
        .q_m     (q_m)
    );

    localparam int NONE = 0;
    localparam int REQ_I = 1;
    localparam int REQ_D = 2;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: who owns memory, who was served last, what memory must see.
    int          owner = NONE;
    int          last = REQ_I;
    logic [18:0] exp_addr;
    logic [15:0] exp_dout;
    logic        exp_wr;
    logic [1:0]  exp_bs;

    logic [15:0] mem [logic [18:0]];
    int  mem_age = 0;
    int  mem_lat = 2;
    bit  rand_lat = 1'b0;
    bit  force_ack = 1'b0;
    bit  rand_mode = 1'b0;
    bit  prev_acc = 1'b0;
    int  glog = 0;
    int  i_ack_cnt = 0;
    int  i_left = 0;
    int  d_left = 0;
    bit  i_acked;
    bit  d_acked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        logic [15:0] v;
        if (mem.exists(a)) return mem[a];
        v = a[15:0];
        return v ^ 16'h5A5A;
    endfunction

    // Arbitration rule for two pending requests, given who was served last.
    function automatic int pick(input bit ia, input bit da, input int lst);
        if (ia && da) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            return (lst == REQ_I) ? REQ_D : REQ_I;
`else
            return REQ_D;
`endif
        end
        if (da) return REQ_D;
        if (ia) return REQ_I;
        return NONE;
    endfunction

    task automatic set_instr(input logic [18:0] a);
        instr_m.access   = 1'b1;
        instr_m.addr     = a;
        instr_m.data_out = 16'($urandom);
        instr_m.wr_en    = 1'($urandom);
        instr_m.bytesel  = 2'($urandom);
    endtask

    task automatic set_data(input logic [18:0] a, input logic w, input logic [15:0] d, input logic [1:0] bs);
        data_m.access   = 1'b1;
        data_m.addr     = a;
        data_m.wr_en    = w;
        data_m.data_out = d;
        data_m.bytesel  = bs;
    endtask

    task automatic rand_instr();
        set_instr(19'h00100 + 19'($urandom_range(0, 7)));
    endtask

    task automatic rand_data();
        set_data(19'h00100 + 19'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 2'($urandom));
    endtask

    // One clock: advance the model over the coming edge, play memory, check, then drive requesters.
    task automatic step();
        logic [15:0] old;
        if (owner != NONE) begin
            if (q_m.ack) begin
                last  = owner;
                owner = NONE;
            end
        end else begin
            owner = pick(instr_m.access, data_m.access, last);
            if (owner == REQ_I) begin
                exp_addr = instr_m.addr; exp_dout = 16'h0; exp_wr = 1'b0; exp_bs = 2'b11;
            end else if (owner == REQ_D) begin
                exp_addr = data_m.addr; exp_dout = data_m.data_out;
                exp_wr = data_m.wr_en; exp_bs = data_m.bytesel;
            end
        end

        @(posedge clk);
        #1;
        if (q_m.access) mem_age++;
        q_m.ack     = (q_m.access && mem_age > mem_lat) || force_ack;
        q_m.data_in = (q_m.ack && q_m.access && !q_m.wr_en) ? mem_rd(q_m.addr) : 16'($urandom);
        #1;

        chk("q_access", 32'(q_m.access), 32'(owner != NONE));
        if (owner != NONE) begin
            chk("q_addr", 32'(q_m.addr), 32'(exp_addr));
            chk("q_data_out", 32'(q_m.data_out), 32'(exp_dout));
            chk("q_wr_en", 32'(q_m.wr_en), 32'(exp_wr));
            chk("q_bytesel", 32'(q_m.bytesel), 32'(exp_bs));
        end
        chk("instr_ack", 32'(instr_m.ack), 32'(owner == REQ_I && q_m.ack));
        chk("data_ack", 32'(data_m.ack), 32'(owner == REQ_D && q_m.ack));
        chk("instr_rdata", 32'(instr_m.data_in), (owner == REQ_I) ? 32'(q_m.data_in) : 32'h0);
        chk("data_rdata", 32'(data_m.data_in), (owner == REQ_D) ? 32'(q_m.data_in) : 32'h0);
        if (owner == REQ_I && q_m.ack)
            chk("instr_mem_word", 32'(instr_m.data_in), 32'(mem_rd(instr_m.addr)));
        if (owner == REQ_D && q_m.ack && !data_m.wr_en)
            chk("data_mem_word", 32'(data_m.data_in), 32'(mem_rd(data_m.addr)));

        if (q_m.access && !prev_acc)
            glog = glog * 4 + ((data_m.access && q_m.addr == data_m.addr) ? REQ_D : REQ_I);
        prev_acc = q_m.access;

        i_acked = (owner == REQ_I) && q_m.ack;
        d_acked = (owner == REQ_D) && q_m.ack;
        if (i_acked) i_ack_cnt++;
        if (q_m.access && q_m.ack) begin
            if (q_m.wr_en) begin
                old = mem_rd(q_m.addr);
                mem[q_m.addr] = {q_m.bytesel[1] ? q_m.data_out[15:8] : old[15:8],
                                 q_m.bytesel[0] ? q_m.data_out[7:0]  : old[7:0]};
            end
            mem_age = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end

        if (i_acked) begin
            if (i_left > 0) begin
                i_left--;
                set_instr(19'h00400 + 19'(i_left));
            end else if (rand_mode && $urandom_range(0, 1) == 1) rand_instr();
            else instr_m.access = 1'b0;
        end
        if (d_acked) begin
            if (d_left > 0) begin
                d_left--;
                set_data(19'h00500 + 19'(d_left), 1'b0, 16'h0, 2'b11);
            end else if (rand_mode && $urandom_range(0, 1) == 1) rand_data();
            else data_m.access = 1'b0;
        end
        if (rand_mode) begin
            if (!instr_m.access && $urandom_range(0, 3) == 0) rand_instr();
            if (!data_m.access && $urandom_range(0, 3) == 0) rand_data();
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1;
        instr_m.access = 1'b0; instr_m.addr = '0; instr_m.data_out = '0;
        instr_m.wr_en = 1'b0; instr_m.bytesel = '0;
        data_m.access = 1'b0; data_m.addr = '0; data_m.data_out = '0;
        data_m.wr_en = 1'b0; data_m.bytesel = '0;
        q_m.ack = 1'b0; q_m.data_in = 16'h1234;
        #2 reset = 1'b0;
        #1;
        chk("rst_q_access", 32'(q_m.access), 32'h0);
        chk("rst_q_wr_en", 32'(q_m.wr_en), 32'h0);
        chk("rst_q_addr", 32'(q_m.addr), 32'h0);
        chk("rst_q_data_out", 32'(q_m.data_out), 32'h0);
        chk("rst_q_bytesel", 32'(q_m.bytesel), 32'h0);
        chk("rst_acks", 32'({instr_m.ack, data_m.ack}), 32'h0);
        chk("rst_rdata", 32'({instr_m.data_in, data_m.data_in}), 32'h0);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;

        // Single instruction read returning BEEF.
        mem[19'h00100] = 16'hBEEF;
        glog = 0; i_ack_cnt = 0;
        set_instr(19'h00100);
        run(6);
        chk("t1_grants", 32'(glog), 32'h1);
        chk("t1_ack_pulses", 32'(i_ack_cnt), 32'h1);

        // Byte write of the low lane only.
        glog = 0;
        set_data(19'h12345, 1'b1, 16'h00A5, 2'b01);
        run(6);
        chk("t2_grants", 32'(glog), 32'h2);
        chk("t2_mem_word", 32'(mem_rd(19'h12345)), 32'h79A5);

        // Simultaneous requests after a data transfer.
        glog = 0;
        set_instr(19'h00200);
        set_data(19'h00300, 1'b0, 16'h0, 2'b11);
        run(12);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        chk("t3_grant_order", 32'(glog), 32'h6);
`else
        chk("t3_grant_order", 32'(glog), 32'h9);
`endif

        // Both requesters re-request immediately after each ack.
        glog = 0; i_left = 1; d_left = 1;
        set_instr(19'h00410);
        set_data(19'h00510, 1'b0, 16'h0, 2'b11);
        run(20);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        chk("t4_grant_order", 32'(glog), 32'd102);
`else
        chk("t4_grant_order", 32'(glog), 32'd165);
`endif

        // Reset while a data write is outstanding.
        set_data(19'h00600, 1'b1, 16'hCAFE, 2'b11);
        run(2);
        chk("t5_pre_access", 32'(q_m.access), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_access", 32'(q_m.access), 32'h0);
        chk("t5_rst_wr_en", 32'(q_m.wr_en), 32'h0);
        chk("t5_rst_acks", 32'({instr_m.ack, data_m.ack}), 32'h0);
        data_m.access = 1'b0;
        owner = NONE; last = REQ_I; mem_age = 0; prev_acc = 1'b0;
        set_instr(19'h00700);
        glog = 0; i_ack_cnt = 0;
        @(negedge clk) reset = 1'b1;
        run(6);
        chk("t5_post_grants", 32'(glog), 32'h1);
        chk("t5_post_acks", 32'(i_ack_cnt), 32'h1);
        chk("t5_mem_untouched", 32'(mem_rd(19'h00600)), 32'(16'h0600 ^ 16'h5A5A));

        // Ack from memory while nothing is outstanding.
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        run(2);
        chk("t6_idle_access", 32'(q_m.access), 32'h0);

        // Randomized traffic with variable memory latency, then drain.
        rand_mode = 1'b1; rand_lat = 1'b1;
        run(3000);
        rand_mode = 1'b0;
        run(30);
        chk("drain_idle", 32'({q_m.access, instr_m.access, data_m.access}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the CPU core.
- Merges the core's instruction bus (prefetch, read-only) and data bus (load/store) onto the single 16-bit memory port.
- Grants one requester at a time and holds the grant until the memory acks.
- Registers all memory-side request signals. Routes ack and read data back to the granted requester only.

Parameters:
None (address [19:1], data 16-bit, bytesel 2-bit are fixed by the core bus format).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (low = reset asserted; deassertion is synchronised externally)
instr_m_addr  input  19  instruction request word address [19:1]
instr_m_data_in  output  16  read data to prefetcher
instr_m_access  input  1  instruction request, held until ack
instr_m_ack  output  1  instruction transfer complete
data_m_addr  input  19  data request word address [19:1]
data_m_data_in  output  16  read data to load/store unit
data_m_data_out  input  16  write data from load/store unit
data_m_access  input  1  data request, held until ack
data_m_ack  output  1  data transfer complete
data_m_wr_en  input  1  data request is a write
data_m_bytesel  input  2  data byte enables
q_m_addr  output  19  memory word address
q_m_data_in  input  16  memory read data
q_m_data_out  output  16  memory write data
q_m_access  output  1  memory request
q_m_ack  input  1  memory transfer complete
q_m_wr_en  output  1  memory write
q_m_bytesel  output  2  memory byte enables

Behaviour:
- Reset (reset low, async): state=IDLE, last_grant=INSTR; q_m_addr/q_m_data_out/q_m_bytesel=0; q_m_access/q_m_wr_en=0. Acks are 0 and data outputs are 0 because grant is none.
- States: IDLE, GRANT_INSTR, GRANT_DATA.
- IDLE:
  - If data_m_access: latch data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel into the q_m_* registers, set q_m_access=1, go to GRANT_DATA.
  - Else if instr_m_access: latch instr_m_addr, wr_en=0, bytesel=2'b11, data_out=0, q_m_access=1, go to GRANT_INSTR.
  - Else stay in IDLE.
  - Default arbitration is fixed data priority.
- GRANT_x: q_m_* held constant. The granted requester's ack is combinational: x_m_ack = q_m_ack (the other requester's ack is 0). Data outputs: x_m_data_in = q_m_data_in when x is granted, 0 otherwise; the non-granted requester's data output is always 0.
- On q_m_ack in GRANT_x: next cycle q_m_access=0, q_m_wr_en=0, state=IDLE, last_grant=x.
- Turnaround: one mandatory idle cycle between transfers (ack cycle, then IDLE cycle, then new access). Minimum request-to-access latency is 1 cycle. Throughput is 1 transfer per (memory latency + 2) cycles.
- Requester contract: x_m_access is held high with stable address/data until x_m_ack. If a requester drops access early, the arbiter still completes the latched transfer and swallows the ack (no ack is forwarded to the dropped requester's next request).
- q_m_ack while IDLE: ignored, no ack forwarded.
- q_m_ack in the same cycle as the access rise: not possible; access is registered, so memory sees it first.
- Simultaneous requests in IDLE: resolved per arbitration rule. The loser waits; its access stays high and it receives no ack.
- Reset mid-transfer: outputs drop immediately. The pending memory cycle is abandoned and the memory must tolerate an access withdrawal.

Optional Feature:
MEM_ARBITER_ROUND_ROBIN_EN
- Defined: when both requests are present in IDLE, grant the requester not equal to last_grant. A single requester is granted regardless of last_grant.
- Undefined: fixed data priority as above; last_grant is still maintained but unused.

Test Plan:
- Single instr read: instr_m_access=1, addr=19'h00100; memory acks 2 cycles after q_m_access with 16'hBEEF -> q_m_addr=19'h00100, q_m_wr_en=0, q_m_bytesel=2'b11; instr_m_ack=1 for one cycle with instr_m_data_in=16'hBEEF; data_m_ack stays 0.
- Data byte write: data_m_access=1, wr_en=1, addr=19'h12345, data_out=16'h00A5, bytesel=2'b01 -> q_m_* carry exactly those values one cycle later; data_m_ack on q_m_ack; q_m_access low the next cycle.
- Contention, macro undefined: both requests raised in the same cycle -> data serviced first; instr serviced after one idle cycle; the instr ack is never asserted during the data transfer.
- Contention, macro defined, last_grant=DATA: both requests raised -> instr granted first, then data. Repeat both back-to-back -> grants alternate I,D,I,D.
- Reset mid-transfer: assert reset low while in GRANT_DATA before ack -> q_m_access=0 asynchronously in the same cycle; after release, a pending instr request is granted normally.
- Spurious ack: pulse q_m_ack while IDLE with no requests -> instr_m_ack=data_m_ack=0; state stays IDLE.
